tdc_readout: RTL and testbench

//  Downstream result stage of the time-to-digital path. Captures the event

---
 rtl/tdc_readout_if.sv | 27 ++
 rtl/tdc_readout.sv | 162 ++++++++++++++++
 tb/tb_tdc_readout.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_readout_if.sv
// Signal bundle between the TDC controller/counter side and the readout stage.
// The master modport belongs to the upstream side. The slave modport belongs to the readout.
interface tdc_readout_if #(
  parameter int COUNTER_BITS = 8
);
  logic                    running;
  logic [COUNTER_BITS-1:0] count_in;
  logic                    rd_start;
  logic                    valid;
  logic                    busy;
  logic                    sframe;
  logic                    sdo;
  logic                    done;
  logic                    ovf;
  logic                    lost;
  logic [1:0]              dbg_state;

  modport master (
    output running, count_in, rd_start,
    input  valid, busy, sframe, sdo, done, ovf, lost, dbg_state
  );

  modport slave (
    input  running, count_in, rd_start,
    output valid, busy, sframe, sdo, done, ovf, lost, dbg_state
  );
endinterface

// File: rtl/tdc_readout.sv
// TDC result stage: captures count_in when running falls, then shifts {ovf, lost, result} out MSB first.
// Define TDC_READOUT_PARITY_EN to append an even-parity trailing bit.
module tdc_readout #(
  parameter int COUNTER_BITS = 8,
  parameter int BIT_DIV      = 2
) (
  input  logic          clk,
  input  logic          rst,
  tdc_readout_if.slave  io
);

`ifdef TDC_READOUT_PARITY_EN
  localparam int F = COUNTER_BITS + 3;
`else
  localparam int F = COUNTER_BITS + 2;
`endif
  localparam int CW = $clog2(F + 1);
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(F - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    running_q, running_d;
  logic [COUNTER_BITS-1:0] result_q, result_d;
  logic [F-1:0]            shreg_q, shreg_d;
  logic [DW-1:0]           div_q, div_d;
  logic [CW-1:0]           bitcnt_q, bitcnt_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    sframe_q, sframe_d;
  logic                    sdo_q, sdo_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    lost_q, lost_d;
  logic                    capture;
  logic [F-1:0]            frame_w;

  assign capture = running_q & ~io.running;

`ifdef TDC_READOUT_PARITY_EN
  assign frame_w = {ovf_q, lost_q, result_q, ^{ovf_q, lost_q, result_q}};
`else
  assign frame_w = {ovf_q, lost_q, result_q};
`endif

  // Handshake: rd_start is a one-cycle request that is honoured only in HOLD
  // with no capture on the same edge. Otherwise it is dropped. done pulses once after the last bit.
  always_comb begin
    state_d   = state_q;
    running_d = io.running;
    result_d  = result_q;
    shreg_d   = shreg_q;
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    sframe_d  = sframe_q;
    sdo_d     = sdo_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    lost_d    = lost_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          result_d = io.count_in;
          ovf_d    = &io.count_in;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (capture) begin
          result_d = io.count_in;
          ovf_d    = &io.count_in;
          lost_d   = 1'b1;
        end else if (io.rd_start) begin
          shreg_d  = frame_w;
          sdo_d    = frame_w[F-1];
          lost_d   = 1'b0;
          sframe_d = 1'b1;
          busy_d   = 1'b1;
          div_d    = '0;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A sample arriving mid-frame is discarded; only the loss is recorded.
        if (capture) lost_d = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            shreg_d  = '0;
            bitcnt_d = '0;
            sdo_d    = 1'b0;
            sframe_d = 1'b0;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            shreg_d  = shreg_q << 1;
            sdo_d    = shreg_q[F-2];
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      result_q  <= '0;
      shreg_q   <= '0;
      div_q     <= '0;
      bitcnt_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sframe_q  <= 1'b0;
      sdo_q     <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      result_q  <= result_d;
      shreg_q   <= shreg_d;
      div_q     <= div_d;
      bitcnt_q  <= bitcnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      sframe_q  <= sframe_d;
      sdo_q     <= sdo_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
    end
  end

  assign io.valid     = valid_q;
  assign io.busy      = busy_q;
  assign io.sframe    = sframe_q;
  assign io.sdo       = sdo_q;
  assign io.done      = done_q;
  assign io.ovf       = ovf_q;
  assign io.lost      = lost_q;
  assign io.dbg_state = state_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Bench for tdc_readout. It uses a transaction-level model that holds a value, flags and the expected frame bit list.
// Honours TDC_READOUT_PARITY_EN for the expected frame length and trailing bit.
module tb_tdc_readout;
  localparam int CB = 8;
  localparam int BD = 2;
`ifdef TDC_READOUT_PARITY_EN
  localparam int F = CB + 3;
`else
  localparam int F = CB + 2;
`endif

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic          m_have;
  logic          m_ovf;
  logic          m_lost;
  logic [CB-1:0] m_res;
  logic [0:0]    exp_q[$];

  tdc_readout_if #(.COUNTER_BITS(CB)) io ();

  tdc_readout #(.COUNTER_BITS(CB), .BIT_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    n_tests++;
    assert (io.dbg_state === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, io.dbg_state, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_capture(input logic [CB-1:0] v);
    if (m_have) m_lost = 1'b1;
    m_res  = v;
    m_ovf  = &v;
    m_have = 1'b1;
  endtask

  task automatic model_reset();
    m_have = 1'b0;
    m_ovf  = 1'b0;
    m_lost = 1'b0;
    m_res  = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".valid"},  io.valid,  m_have);
    check({tag, ".ovf"},    io.ovf,    m_ovf);
    check({tag, ".lost"},   io.lost,   m_lost);
    check({tag, ".busy"},   io.busy,   1'b0);
    check({tag, ".sframe"}, io.sframe, 1'b0);
    check({tag, ".sdo"},    io.sdo,    1'b0);
  endtask

  task automatic capture(input logic [CB-1:0] v);
    io.count_in = v;
    io.running  = 1'b1;
    tick();
    io.running  = 1'b0;
    tick();
    model_capture(v);
    check_quiet("capture");
    io.count_in = 8'($urandom);
  endtask

  task automatic same_edge(input logic [CB-1:0] v);
    io.count_in = v;
    io.running  = 1'b1;
    tick();
    io.running  = 1'b0;
    io.rd_start = 1'b1;
    tick();
    io.rd_start = 1'b0;
    model_capture(v);
    check_quiet("same_edge");
    tick();
    check_quiet("same_edge_after");
  endtask

  task automatic idle_rd();
    io.rd_start = 1'b1;
    tick();
    io.rd_start = 1'b0;
    check_quiet("idle_rd");
    tick();
    check_quiet("idle_rd_after");
  endtask

  // cap_at < 0: no capture during the frame; otherwise a running pulse starts at that frame cycle.
  task automatic read_frame(input int cap_at, input logic [CB-1:0] cap_v);
    exp_q.delete();
    exp_q.push_back(m_ovf);
    exp_q.push_back(m_lost);
    for (int i = CB - 1; i >= 0; i--) exp_q.push_back(m_res[i]);
`ifdef TDC_READOUT_PARITY_EN
    exp_q.push_back(^{m_ovf, m_lost, m_res});
`endif
    m_lost = 1'b0;
    io.rd_start = 1'b1;
    tick();
    io.rd_start = 1'b0;
    for (int c = 0; c < BD * F; c++) begin
      check("frame.sframe", io.sframe, 1'b1);
      check("frame.busy",   io.busy,   1'b1);
      check("frame.valid",  io.valid,  1'b1);
      check("frame.sdo",    io.sdo,    exp_q[c / BD]);
      if (c == 0) check("frame.lost_cleared", io.lost, 1'b0);
      if (c == cap_at) begin
        io.count_in = cap_v;
        io.running  = 1'b1;
      end
      if (c == cap_at + 1) io.running = 1'b0;
      tick();
    end
    if (cap_at >= 0) m_lost = 1'b1;
    m_have = 1'b0;
    m_ovf  = 1'b0;
    check("end.done", io.done, 1'b1);
    check_quiet("end");
    check_state("end.state", 2'd0);
    tick();
    check("end.done_pulse", io.done, 1'b0);
  endtask

  initial begin
    logic [CB-1:0] a;
    logic [CB-1:0] b;
    int            op;
    rst         = 1'b1;
    io.running  = 1'b0;
    io.count_in = '0;
    io.rd_start = 1'b0;
    model_reset();
    tick();
    tick();
    check_quiet("reset");
    check("reset.done", io.done, 1'b0);
    check_state("reset.state", 2'd0);
    rst = 1'b0;
    tick();
    check_quiet("post_reset");

    // Basic capture and read of a mixed pattern.
    capture(8'hA5);
    check_state("hold.state", 2'd1);
    read_frame(-1, '0);
    // Saturated value sets ovf.
    capture(8'hFF);
    read_frame(-1, '0);
    // Overwrite in HOLD sets lost.
    capture(8'h03);
    capture(8'h07);
    read_frame(-1, '0);
    // Capture during SHIFT, then the lost bit travels in the next frame.
    capture(8'h5A);
    read_frame(7, 8'h33);
    capture(8'h11);
    read_frame(-1, '0);
    // Capture and request on the same edge: request dropped.
    capture(8'h22);
    same_edge(8'h44);
    read_frame(-1, '0);
    // Requests in IDLE are ignored.
    idle_rd();

    for (int i = 0; i < 25; i++) begin
      op = int'($urandom_range(0, 4));
      a  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      b  = 8'($urandom);
      case (op)
        0: begin capture(a); read_frame(-1, '0); end
        1: begin capture(a); capture(b); read_frame(-1, '0); end
        2: begin capture(a); read_frame(int'($urandom_range(0, BD * F - 3)), b); end
        3: begin capture(a); same_edge(b); read_frame(-1, '0); end
        default: begin idle_rd(); capture(a); read_frame(-1, '0); end
      endcase
    end

    // Asynchronous reset in the middle of a frame.
    capture(8'hFF);
    io.rd_start = 1'b1;
    tick();
    io.rd_start = 1'b0;
    repeat (5) tick();
    check("pre_rst.sframe", io.sframe, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_quiet("async_rst");
    check_state("async_rst.state", 2'd0);
    tick();
    rst = 1'b0;
    tick();
    check_quiet("after_rst");
    // Low value: with parity enabled, the frame ends in parity bit 1.
    capture(8'h01);
    read_frame(-1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
